// File: rtl/channel_rr_arbiter.sv
// Eight-way round-robin channel arbiter with a one-cycle switchover gap.
// Define TENURE_LIMIT_EN to preempt owners that exceed MAX_TENURE under contention.
module channel_rr_arbiter #(
    parameter int MAX_TENURE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ID0,
    input  logic       ID1,
    input  logic       ID2,
    input  logic       ID3,
    input  logic       ID4,
    input  logic       ID5,
    input  logic       ID6,
    input  logic       ID7,
    output logic [3:0] grant,
    output logic [7:0] grant_onehot,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state, state_nx;
    logic [2:0] ptr, ptr_nx;
    logic [2:0] owner, owner_nx;
    logic [7:0] cnt, cnt_nx;
    logic       tout, tout_nx;

    logic [7:0] req;
    logic [2:0] pick;
    logic [2:0] idx;
    logic       others;
    logic       expire;

    assign req = {ID7, ID6, ID5, ID4, ID3, ID2, ID1, ID0};

    // Scan downward in offset so the lowest offset from ptr wins.
    always_comb begin
        pick = ptr;
        idx  = ptr;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (req[idx]) pick = idx;
        end
    end

    assign others = |(req & ~(8'b1 << owner));

`ifdef TENURE_LIMIT_EN
    assign expire = (cnt == 8'(MAX_TENURE - 1)) && others;
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        owner_nx = owner;
        cnt_nx   = cnt;
        tout_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    owner_nx = pick;
                    cnt_nx   = 8'd0;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (cnt < 8'(MAX_TENURE)) cnt_nx = cnt + 8'd1;
                if (!req[owner]) begin
                    state_nx = GAP;
                    ptr_nx   = owner + 3'd1;
                end else if (expire) begin
                    state_nx = GAP;
                    ptr_nx   = owner + 3'd1;
                    tout_nx  = 1'b1;
                end
            end
            GAP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 3'd0;
            owner <= 3'd0;
            cnt   <= 8'd0;
            tout  <= 1'b0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            owner <= owner_nx;
            cnt   <= cnt_nx;
            tout  <= tout_nx;
        end
    end

    assign grant        = (state == GRANT) ? {1'b1, owner} : 4'b0000;
    assign grant_onehot = (state == GRANT) ? (8'b1 << owner) : 8'h00;
    assign busy         = (state != IDLE);
    assign timeout      = tout;

endmodule

// File: tb/tb_channel_rr_arbiter.sv
// Directed self-checking bench for channel_rr_arbiter (MAX_TENURE=4).
// Tenure steps follow TENURE_LIMIT_EN when it is defined for the build.
module tb_channel_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [3:0] grant;
    logic [7:0] grant_onehot;
    logic       busy;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    channel_rr_arbiter #(.MAX_TENURE(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .ID0         (req[0]),
        .ID1         (req[1]),
        .ID2         (req[2]),
        .ID3         (req[3]),
        .ID4         (req[4]),
        .ID5         (req[5]),
        .ID6         (req[6]),
        .ID7         (req[7]),
        .grant       (grant),
        .grant_onehot(grant_onehot),
        .busy        (busy),
        .timeout     (timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {grant, onehot, busy, timeout} for a given owner view.
    function automatic logic [13:0] ev(input logic v, input int id,
                                       input logic b, input logic t);
        logic [3:0] g;
        logic [7:0] oh;
        g  = v ? {1'b1, 3'(id)} : 4'b0000;
        oh = v ? (8'b1 << id) : 8'h00;
        return {g, oh, b, t};
    endfunction

    task automatic chk(input string tag, input logic [13:0] exp);
        logic [13:0] obs;
        obs = {grant, grant_onehot, busy, timeout};
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset
        step();
        step();
        chk("reset", ev(0, 0, 0, 0));
        rst = 1'b0;

        // ID4 and ID7 together: ID4 first from ptr 0
        req = 8'h90;
        step();
        chk("t1_g4", ev(1, 4, 1, 0));
        req[4] = 1'b0;
        step();
        chk("t1_gap", ev(0, 0, 1, 0));
        step();
        chk("t1_idle", ev(0, 0, 0, 0));
        step();
        chk("t1_g7", ev(1, 7, 1, 0));
        req = 8'h00;
        step();
        step();
        chk("t1_end", ev(0, 0, 0, 0));

        // all high, rotation 0..7,0 (ptr wrapped to 0)
        req = 8'hFF;
        for (int n = 0; n < 9; n++) begin
            step();
            chk($sformatf("rot_g%0d_a", n), ev(1, n % 8, 1, 0));
            step();
            chk($sformatf("rot_g%0d_b", n), ev(1, n % 8, 1, 0));
            req[n % 8] = 1'b0;
            step();
            chk($sformatf("rot_gap%0d", n), ev(0, 0, 1, 0));
            req[n % 8] = 1'b1;
            step();
            chk($sformatf("rot_idle%0d", n), ev(0, 0, 0, 0));
        end
        req = 8'h00;
        step();
        step();

        // ptr is 1: ID5 alone, then ID2+ID6 -> ID6 first
        req = 8'h20;
        step();
        chk("t3_g5", ev(1, 5, 1, 0));
        req = 8'h00;
        step();
        step();
        req = 8'h44;
        step();
        chk("t3_g6", ev(1, 6, 1, 0));
        req[6] = 1'b0;
        step();
        chk("t3_gap", ev(0, 0, 1, 0));
        step();
        step();
        chk("t3_g2", ev(1, 2, 1, 0));
        req = 8'h00;
        step();
        step();

        // ptr is 3: ID1 owner, ID3 waits
        req = 8'h02;
        step();
        chk("t4_g1_c0", ev(1, 1, 1, 0));
        req[3] = 1'b1;
        for (int c = 1; c < 4; c++) begin
            step();
            chk($sformatf("t4_g1_c%0d", c), ev(1, 1, 1, 0));
        end
`ifdef TENURE_LIMIT_EN
        step();
        chk("t4_preempt", ev(0, 0, 1, 1));
        step();
        chk("t4_idle", ev(0, 0, 0, 0));
        step();
        chk("t4_g3", ev(1, 3, 1, 0));
`else
        for (int c = 4; c < 10; c++) begin
            step();
            chk($sformatf("t4_hold_c%0d", c), ev(1, 1, 1, 0));
        end
        req[1] = 1'b0;
        step();
        chk("t4_gap", ev(0, 0, 1, 0));
        step();
        step();
        chk("t4_g3", ev(1, 3, 1, 0));
`endif
        req = 8'h00;
        step();
        step();

        // ptr is 4: release on the expiry edge is a plain release
        req = 8'h02;
        step();
        chk("t5_g1", ev(1, 1, 1, 0));
        req[3] = 1'b1;
        step();
        step();
        step();
        chk("t5_g1_last", ev(1, 1, 1, 0));
        req[1] = 1'b0;
        step();
        chk("t5_gap_noto", ev(0, 0, 1, 0));
        step();
        chk("t5_idle", ev(0, 0, 0, 0));
        step();
        chk("t5_g3", ev(1, 3, 1, 0));
        req = 8'h00;
        step();
        step();

        // reset while ID6 owns; ptr returns to 0
        req = 8'h40;
        step();
        chk("t6_g6", ev(1, 6, 1, 0));
        rst = 1'b1;
        step();
        chk("t6_rst", ev(0, 0, 0, 0));
        rst = 1'b0;
        req = 8'h41;
        step();
        chk("t6_g0", ev(1, 0, 1, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
